quadrature_pulse_decoder: RTL and testbench

//  Front end for a rotary/quadrature encoder. Emits debounced, stretched pulse_up/pulse_down

---
 rtl/qdec_defs.sv | 34 +++
 rtl/qdec_glitch_filter.sv | 54 +++++
 rtl/quadrature_pulse_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_quadrature_pulse_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_defs.sv
// Shared definitions for the quadrature pulse decoder: FSM states, Gray step
// classification and pending-queue saturation limits.
package qdec_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UP_HOLD = 2'd1,
    ST_DN_HOLD = 2'd2,
    ST_GAP     = 2'd3
  } qdec_state_e;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_DEC     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } qdec_step_e;

  localparam logic signed [3:0] PEND_MAX = 4'sd7;
  localparam logic signed [3:0] PEND_MIN = -4'sd7;

  // Classify a {a,b} -> {a,b} transition; CW order is 00,01,11,10.
  function automatic qdec_step_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
    qdec_step_e step;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_INC;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = STEP_DEC;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: step = STEP_ILLEGAL;
      default:                            step = STEP_NONE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/qdec_glitch_filter.sv
// Per-channel 2-flop synchroniser followed by a stable-level filter; while
// unprimed the filtered value simply follows the synchronised pin.
module qdec_glitch_filter #(
  parameter int FILTER_CYCLES = 1000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic primed_i,
  input  logic pin_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_val;

  assign sync_val = sync_q[1];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= 2'b00;
      filt_q <= 1'b0;
      cnt_q  <= CNT_LOAD;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Down-counter reloads whenever the levels agree; terminal count accepts the new level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!primed_i) begin
      filt_d = sync_val;
      cnt_d  = CNT_LOAD;
    end else if (sync_val == filt_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      filt_d = sync_val;
      cnt_d  = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quadrature_pulse_decoder.sv
// Quadrature encoder front end: filtered Gray decode into stretched up/down pulses.
// Optional detent position counter is built when QDEC_POSITION_EN is defined.
//
// state      | meaning
// ST_IDLE    | no pulse, waiting for pending != 0
// ST_UP_HOLD | pulse_up high for PULSE_CYCLES
// ST_DN_HOLD | pulse_down high for PULSE_CYCLES
// ST_GAP     | both low for PULSE_CYCLES before next pulse
module quadrature_pulse_decoder
  import qdec_defs::*;
#(
  parameter int FILTER_CYCLES    = 1000,
  parameter int PULSE_CYCLES     = 50000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       enable,
  output logic       pulse_up,
  output logic       pulse_down,
  output logic [7:0] position,
  output logic       error
);

  localparam int PRIME_CYCLES = FILTER_CYCLES + 3;
  localparam int SW = $clog2(PRIME_CYCLES + 1);
  localparam int TW = $clog2(PULSE_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic signed [3:0] STEPS_S = 4'(STEPS_PER_DETENT);

  logic [SW-1:0]      startup_q, startup_d;
  logic               primed;
  logic               a_f, b_f;
  logic [1:0]         prev_state_q;
  qdec_step_e         step;
  logic signed [2:0]  substep_q, substep_d;
  logic signed [3:0]  sub_ext, sub_inc, sub_dec;
  logic signed [3:0]  pending_q, pending_d, pend_evt;
  logic               up_evt, dn_evt, illegal, sat_err;
  logic               error_q, error_d;
  qdec_state_e        state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               deq_up, deq_dn;

  assign primed    = (startup_q == SW'(PRIME_CYCLES));
  assign startup_d = primed ? startup_q : startup_q + 1'b1;

  qdec_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .clk_in   (clk_in),
    .reset    (reset),
    .primed_i (primed),
    .pin_i    (enc_a),
    .filt_o   (a_f)
  );

  qdec_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .clk_in   (clk_in),
    .reset    (reset),
    .primed_i (primed),
    .pin_i    (enc_b),
    .filt_o   (b_f)
  );

  assign step    = gray_step(prev_state_q, {a_f, b_f});
  assign sub_ext = {substep_q[2], substep_q};
  assign sub_inc = sub_ext + 4'sd1;
  assign sub_dec = sub_ext - 4'sd1;

  always_comb begin
    substep_d = substep_q;
    up_evt    = 1'b0;
    dn_evt    = 1'b0;
    illegal   = 1'b0;
    if (!enable) begin
      substep_d = 3'sd0;
    end else if (primed) begin
      case (step)
        STEP_INC: begin
          if (sub_inc == STEPS_S) begin
            up_evt    = 1'b1;
            substep_d = 3'sd0;
          end else begin
            substep_d = sub_inc[2:0];
          end
        end
        STEP_DEC: begin
          if (sub_dec == -STEPS_S) begin
            dn_evt    = 1'b1;
            substep_d = 3'sd0;
          end else begin
            substep_d = sub_dec[2:0];
          end
        end
        STEP_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Events land in pending before the FSM looks at it, so a pulse starts the next cycle.
  always_comb begin
    pend_evt = pending_q;
    sat_err  = 1'b0;
    if (!enable) begin
      pend_evt = 4'sd0;
    end else if (up_evt) begin
      if (pending_q == PEND_MAX) sat_err = 1'b1;
      else                       pend_evt = pending_q + 4'sd1;
    end else if (dn_evt) begin
      if (pending_q == PEND_MIN) sat_err = 1'b1;
      else                       pend_evt = pending_q - 4'sd1;
    end
  end

  always_comb begin
    if (deq_up)      pending_d = pend_evt - 4'sd1;
    else if (deq_dn) pending_d = pend_evt + 4'sd1;
    else             pending_d = pend_evt;
  end

  assign error_d = error_q | illegal | sat_err;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      startup_q    <= '0;
      prev_state_q <= 2'b00;
      substep_q    <= 3'sd0;
      pending_q    <= 4'sd0;
      error_q      <= 1'b0;
    end else begin
      startup_q    <= startup_d;
      prev_state_q <= {a_f, b_f};
      substep_q    <= substep_d;
      pending_q    <= pending_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deq_up  = 1'b0;
    deq_dn  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_evt > 4'sd0) begin
          state_d = ST_UP_HOLD;
          timer_d = TIMER_LOAD;
          deq_up  = 1'b1;
        end else if (pend_evt < 4'sd0) begin
          state_d = ST_DN_HOLD;
          timer_d = TIMER_LOAD;
          deq_dn  = 1'b1;
        end
      end
      ST_UP_HOLD, ST_DN_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = TIMER_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_up   = (state_q == ST_UP_HOLD);
    pulse_down = (state_q == ST_DN_HOLD);
  end

  assign error = error_q;

`ifdef QDEC_POSITION_EN
  logic [7:0] position_q, position_d;

  always_comb begin
    position_d = position_q;
    if (up_evt)      position_d = position_q + 8'd1;
    else if (dn_evt) position_d = position_q - 8'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) position_q <= 8'h00;
    else       position_q <= position_d;
  end

  assign position = position_q;
`else
  assign position = 8'h00;
`endif

endmodule

// File: tb/tb_quadrature_pulse_decoder.sv
// Directed bench for quadrature_pulse_decoder; a second instance with long
// pulses exercises pending-queue saturation.
module tb_quadrature_pulse_decoder;

  localparam int FC  = 4;
  localparam int PC  = 3;
  localparam int SPD = 4;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       enc_a  = 1'b0;
  logic       enc_b  = 1'b0;
  logic       enable = 1'b1;
  logic       pulse_up, pulse_down, error;
  logic [7:0] position;
  logic       sat_up, sat_dn, sat_err;
  logic [7:0] sat_pos;

  always #5 clk_in = ~clk_in;

  quadrature_pulse_decoder #(
    .FILTER_CYCLES(FC), .PULSE_CYCLES(PC), .STEPS_PER_DETENT(SPD)
  ) dut (
    .clk_in(clk_in), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .pulse_up(pulse_up), .pulse_down(pulse_down), .position(position), .error(error)
  );

  quadrature_pulse_decoder #(
    .FILTER_CYCLES(FC), .PULSE_CYCLES(400), .STEPS_PER_DETENT(SPD)
  ) dut_sat (
    .clk_in(clk_in), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enable(enable),
    .pulse_up(sat_up), .pulse_down(sat_dn), .position(sat_pos), .error(sat_err)
  );

  int checks = 0;
  int errors = 0;

  int up_rises = 0, up_high = 0, dn_rises = 0, dn_high = 0;
  int bad_runs = 0, overlaps = 0, min_gap = 1000;
  int up_run = 0, dn_run = 0, low_run = 0;
  logic seen_pulse = 1'b0, prev_up = 1'b0, prev_dn = 1'b0;

  // Pulse monitor on the main instance; runs truncated by reset are not judged.
  always @(negedge clk_in) begin
    if (reset) begin
      up_run     <= 0;
      dn_run     <= 0;
      low_run    <= 0;
      seen_pulse <= 1'b0;
      prev_up    <= 1'b0;
      prev_dn    <= 1'b0;
    end else begin
      if (pulse_up && pulse_down) overlaps <= overlaps + 1;
      if (pulse_up) begin
        up_high <= up_high + 1;
        up_run  <= up_run + 1;
        if (!prev_up) begin
          up_rises <= up_rises + 1;
          if (seen_pulse && low_run < min_gap) min_gap <= low_run;
        end
      end else begin
        if (prev_up) begin
          if (up_run != PC) bad_runs <= bad_runs + 1;
          seen_pulse <= 1'b1;
        end
        up_run <= 0;
      end
      if (pulse_down) begin
        dn_high <= dn_high + 1;
        dn_run  <= dn_run + 1;
        if (!prev_dn) begin
          dn_rises <= dn_rises + 1;
          if (seen_pulse && low_run < min_gap) min_gap <= low_run;
        end
      end else begin
        if (prev_dn) begin
          if (dn_run != PC) bad_runs <= bad_runs + 1;
          seen_pulse <= 1'b1;
        end
        dn_run <= 0;
      end
      low_run <= (!pulse_up && !pulse_down) ? low_run + 1 : 0;
      prev_up <= pulse_up;
      prev_dn <= pulse_down;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic phase(input logic a, input logic b, input int hold);
    enc_a = a;
    enc_b = b;
    cycles(hold);
  endtask

  task automatic cw(input int hold);
    phase(1'b0, 1'b1, hold);
    phase(1'b1, 1'b1, hold);
    phase(1'b1, 1'b0, hold);
    phase(1'b0, 1'b0, hold);
  endtask

  task automatic ccw(input int hold);
    phase(1'b1, 1'b0, hold);
    phase(1'b1, 1'b1, hold);
    phase(1'b0, 1'b1, hold);
    phase(1'b0, 1'b0, hold);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(10);
  endtask

  function automatic int exp_pos(input int p);
`ifdef QDEC_POSITION_EN
    return p & 255;
`else
    return 0;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_ur, b_uh, b_dr, b_dh, waited;

    reset = 1'b1;
    cycles(3);
    check_eq("rst_pulse_up", pulse_up, 0);
    check_eq("rst_pulse_down", pulse_down, 0);
    check_eq("rst_position", position, 0);
    check_eq("rst_error", error, 0);
    reset = 1'b0;
    cycles(10);

    b_ur = up_rises; b_uh = up_high; b_dr = dn_rises;
    phase(1'b0, 1'b0, 8);
    cw(8);
    cycles(20);
    check_eq("t1_up_rises", up_rises - b_ur, 1);
    check_eq("t1_up_high", up_high - b_uh, 3);
    check_eq("t1_dn_rises", dn_rises - b_dr, 0);
    check_eq("t1_position", position, exp_pos(1));
    check_eq("t1_error", error, 0);

    b_ur = up_rises; b_dr = dn_rises; b_dh = dn_high;
    ccw(8);
    cycles(20);
    check_eq("t2_dn_rises", dn_rises - b_dr, 1);
    check_eq("t2_dn_high", dn_high - b_dh, 3);
    check_eq("t2_up_rises", up_rises - b_ur, 0);
    check_eq("t2_position", position, exp_pos(0));

    b_ur = up_rises; b_dr = dn_rises;
    enc_a = 1'b1;
    cycles(2);
    enc_a = 1'b0;
    cycles(20);
    check_eq("t3_glitch_pulses", (up_rises - b_ur) + (dn_rises - b_dr), 0);
    phase(1'b1, 1'b0, 6);
    phase(1'b1, 1'b1, 8);
    phase(1'b0, 1'b1, 8);
    phase(1'b0, 1'b0, 8);
    cycles(20);
    check_eq("t3_dn_rises", dn_rises - b_dr, 1);
    check_eq("t3_position_wrap", position, exp_pos(255));
    check_eq("t3_error", error, 0);

    b_ur = up_rises; b_dr = dn_rises;
    phase(1'b1, 1'b1, 8);
    check_eq("t4_error_set", error, 1);
    phase(1'b0, 1'b0, 8);
    cycles(20);
    check_eq("t4_error_sticky", error, 1);
    check_eq("t4_no_pulse", (up_rises - b_ur) + (dn_rises - b_dr), 0);
    do_reset();
    check_eq("t4_error_cleared", error, 0);
    check_eq("t4_position_reset", position, 0);

    b_ur = up_rises; b_uh = up_high;
    repeat (3) cw(8);
    cycles(20);
    check_eq("t5_up_rises", up_rises - b_ur, 3);
    check_eq("t5_up_high", up_high - b_uh, 9);
    check_eq("t5_bad_runs", bad_runs, 0);
    check_eq("t5_min_gap_ok", (min_gap >= PC) ? 1 : 0, 1);
    check_eq("t5_position", position, exp_pos(3));
    check_eq("t5_error", error, 0);

    do_reset();
    b_ur = up_rises;
    repeat (9) cw(6);
    cycles(5);
    check_eq("t5b_sat_error", sat_err, 1);
    check_eq("t5b_sat_pulse_active", sat_up, 1);
    check_eq("t5b_sat_position", sat_pos, exp_pos(9));
    check_eq("t5b_main_error", error, 0);
    cycles(30);
    check_eq("t5b_main_up_rises", up_rises - b_ur, 9);
    check_eq("t5b_main_position", position, exp_pos(9));

    do_reset();
    b_ur = up_rises;
    cw(8);
    waited = 0;
    while (!pulse_up && waited < 50) begin
      cycles(1);
      waited++;
    end
    check_eq("t6_pulse_seen", pulse_up, 1);
    reset = 1'b1;
    cycles(1);
    check_eq("t6_reset_drop", pulse_up, 0);
    reset = 1'b0;
    cycles(30);
    check_eq("t6_no_resume", up_rises - b_ur, 1);
    check_eq("t6_position", position, 0);

    b_ur = up_rises; b_dr = dn_rises;
    enable = 1'b0;
    cw(8);
    cycles(20);
    check_eq("t6b_disabled_pulses", (up_rises - b_ur) + (dn_rises - b_dr), 0);
    check_eq("t6b_disabled_position", position, 0);
    enable = 1'b1;
    cw(8);
    cycles(20);
    check_eq("t6b_reenabled_up", up_rises - b_ur, 1);
    check_eq("t6b_reenabled_position", position, exp_pos(1));

    check_eq("overlap_cycles", overlaps, 0);
    check_eq("final_bad_runs", bad_runs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
